cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001: Parameter NUM_UNITS, default 4, number of functional units sharing the common data bus (legal 2..8).
REQ-002: Parameter TAG_W, default 3, ROB tag width.
REQ-003: clk  input  1  sole clock; all state updates on rising edge.
REQ-004: rst_n  input  1  reset, asynchronous, active-low.
REQ-005: flush  input  1  mispredict flush; discards pending broadcast.
REQ-006: req_valid  input  NUM_UNITS  unit i holds a finished result.
REQ-007: req_tag  input  NUM_UNITS x TAG_W  ROB tag of unit i's result.
REQ-008: req_data  input  NUM_UNITS x cdb_data  result payload of unit i.
REQ-009: req_ready  output  NUM_UNITS  one-hot grant; unit i's result accepted this cycle.
REQ-010: rob_ready  input  1  ROB/reservation stations accept the current broadcast.
REQ-011: cdb_valid  output  1  broadcast present on bus.
REQ-012: cdb_tag  output  TAG_W  ROB tag being broadcast.
REQ-013: cdb_out  output  cdb_data  payload being broadcast.
REQ-014: cdb_src  output  3  index of unit that produced the broadcast.

Function
REQ-015: Bus outputs (cdb_valid, cdb_tag, cdb_out, cdb_src) SHALL be registered; no combinational path from req_* to them.
REQ-016: A broadcast SHALL complete in a cycle where cdb_valid=1 and rob_ready=1.
REQ-017: Arbiter SHALL grant only when the output register is free: cdb_valid=0, or the current broadcast completes, and flush=0.
REQ-018: At most one req_ready bit SHALL be high per cycle, only for a unit with req_valid=1; req_ready may depend combinationally on req_valid, rob_ready, flush.
REQ-019: Handshake: transfer occurs when req_valid[i] and req_ready[i] are both high; the unit SHALL hold valid/tag/data stable until then.
REQ-020: Latency: result granted at edge t SHALL appear on the bus from t+1, held until the broadcast completes.
REQ-021: When no grant occurs and the current broadcast completes, cdb_valid SHALL fall to 0 on the next edge.
REQ-022: Round-robin pointer SHALL select the first requesting unit at index >= pointer, wrapping modulo NUM_UNITS; after a grant to unit k pointer becomes (k+1) mod NUM_UNITS.
REQ-023: Pointer SHALL not change in cycles without a grant.
REQ-024: flush=1 SHALL clear cdb_valid on the next edge, force req_ready=0 that cycle, retain pointer, ignore rob_ready.
REQ-025: rob_ready=0 with cdb_valid=1 SHALL hold all bus outputs unchanged and req_ready=0.
REQ-026: No requester SHALL wait more than NUM_UNITS-1 grants once valid (round-robin build).

Reset
REQ-027: While rst_n=0: cdb_valid=0, cdb_tag=0, cdb_out=0, cdb_src=0, pointer=0, req_ready=0.
REQ-028: Reset assertion mid-broadcast SHALL drop the broadcast immediately without completion.

Configuration
REQ-029: Macro CDB_ROUND_ROBIN_EN defined: arbitration per REQ-022/023/026.
REQ-030: Macro CDB_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins; pointer logic absent; REQ-026 waived.

Structure
REQ-031: cdb_data stays in tomasula_types; add typedef cdb_req (tag + cdb_data) and constant NUM_CDB_UNITS=4 there.
REQ-032: One combinational sub-module rr_picker (request vector + pointer in, one-hot grant out); no other sub-modules.

Verification
REQ-033: Reset, then req_valid=0001, tag 3'd5, data 32'hA5 with rob_ready=1 -> req_ready=0001 at t, cdb_valid=1, cdb_tag=5, cdb_src=0 at t+1, cdb_valid=0 at t+2.
REQ-034: All four units valid continuously, rob_ready=1 (RR build) -> grants 0,1,2,3,0 on consecutive cycles, one broadcast per cycle.
REQ-035: Same stimulus, fixed-priority build -> unit 0 granted every cycle, units 1-3 never granted.
REQ-036: Broadcast tag 2 pending, rob_ready=0 for 3 cycles -> bus holds tag 2, req_ready=0 throughout; grant resumes the cycle rob_ready=1.
REQ-037: flush=1 while cdb_valid=1 and unit 2 requesting -> req_ready=0, cdb_valid=0 next cycle, pointer unchanged.
REQ-038: rst_n low asynchronously mid-broadcast -> cdb_valid=0 before next clock edge; after release first grant goes to unit 0.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared Tomasulo datapath types used by the common-data-bus arbiter and its interface.
package tomasula_types;

    typedef logic [31:0] cdb_data;

    localparam int NUM_CDB_UNITS = 4;
    localparam int CDB_TAG_W     = 3;
    localparam int CDB_SRC_W     = 3;

    typedef struct packed {
        logic [CDB_TAG_W-1:0] tag;
        cdb_data              data;
    } cdb_req;

    // Index of the set bit in a one-hot vector (zero when the vector is empty).
    function automatic logic [CDB_SRC_W-1:0] onehot_to_idx(input logic [7:0] onehot);
        logic [CDB_SRC_W-1:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) begin
                idx = CDB_SRC_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Functional-unit request side, ROB acceptance and broadcast bus of the CDB arbiter.
interface cdb_arbiter_if #(
    parameter int NUM_UNITS = 4,
    parameter int TAG_W     = 3
);
    import tomasula_types::*;

    logic                              flush;
    logic [NUM_UNITS-1:0]              req_valid;
    logic [NUM_UNITS-1:0][TAG_W-1:0]   req_tag;
    cdb_data [NUM_UNITS-1:0]           req_data;
    logic [NUM_UNITS-1:0]              req_ready;
    logic                              rob_ready;
    logic                              cdb_valid;
    logic [TAG_W-1:0]                  cdb_tag;
    cdb_data                           cdb_out;
    logic [CDB_SRC_W-1:0]              cdb_src;

    modport master (
        input  flush, req_valid, req_tag, req_data, rob_ready,
        output req_ready, cdb_valid, cdb_tag, cdb_out, cdb_src
    );

    modport slave (
        output flush, req_valid, req_tag, req_data, rob_ready,
        input  req_ready, cdb_valid, cdb_tag, cdb_out, cdb_src
    );

endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational picker: first set request at or after the pointer, wrapping, as a one-hot grant.
module rr_picker #(
    parameter int NUM_UNITS = 4,
    parameter int PTR_W     = 2
) (
    input  logic [NUM_UNITS-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic [NUM_UNITS-1:0] grant
);

    // Scan forward from the pointer and keep only the first hit.
    always_comb begin
        logic found;
        int   idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < NUM_UNITS; off++) begin
            idx = (int'(ptr) + off) % NUM_UNITS;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: picks one finished unit per free bus slot and registers its broadcast.
// Define CDB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest index always wins.
module cdb_arbiter
    import tomasula_types::*;
#(
    parameter int NUM_UNITS = 4,
    parameter int TAG_W     = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    cdb_arbiter_if.master  bus
);

    localparam int PTR_W = $clog2(NUM_UNITS);

    logic                  grant_ok_s;
    logic [NUM_UNITS-1:0]  pick_s;
    logic [NUM_UNITS-1:0]  grant_s;
    logic [CDB_SRC_W-1:0]  grant_idx_s;
    logic [PTR_W-1:0]      grant_sel_s;
    logic [PTR_W-1:0]      ptr_s;

    logic                  cdb_valid_r;
    logic [TAG_W-1:0]      cdb_tag_r;
    cdb_data               cdb_out_r;
    logic [CDB_SRC_W-1:0]  cdb_src_r;

    rr_picker #(
        .NUM_UNITS (NUM_UNITS),
        .PTR_W     (PTR_W)
    ) u_picker (
        .req   (bus.req_valid),
        .ptr   (ptr_s),
        .grant (pick_s)
    );

    // The output slot is free when empty or draining this cycle; flush and reset veto any grant.
    always_comb begin
        grant_ok_s = rst_n & ~bus.flush & (~cdb_valid_r | bus.rob_ready);
        if (grant_ok_s) begin
            grant_s = pick_s;
        end else begin
            grant_s = '0;
        end
        grant_idx_s = onehot_to_idx(8'(grant_s));
        grant_sel_s = grant_idx_s[PTR_W-1:0];
    end

`ifdef CDB_ROUND_ROBIN_EN
    logic [PTR_W-1:0] ptr_r;

    // Pointer moves just past the granted unit and is frozen otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (|grant_s) begin
            if (grant_sel_s == PTR_W'(NUM_UNITS - 1)) begin
                ptr_r <= '0;
            end else begin
                ptr_r <= grant_sel_s + PTR_W'(1);
            end
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr_s = ptr_r;
`else
    assign ptr_s = '0;
`endif

    // Broadcast register: flush kills it, a grant reloads it, a completed broadcast empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid_r <= 1'b0;
            cdb_tag_r   <= '0;
            cdb_out_r   <= 32'd0;
            cdb_src_r   <= 3'd0;
        end else if (bus.flush) begin
            cdb_valid_r <= 1'b0;
        end else if (|grant_s) begin
            cdb_valid_r <= 1'b1;
            cdb_tag_r   <= bus.req_tag[grant_sel_s];
            cdb_out_r   <= bus.req_data[grant_sel_s];
            cdb_src_r   <= grant_idx_s;
        end else if (bus.rob_ready) begin
            cdb_valid_r <= 1'b0;
        end else begin
            cdb_valid_r <= cdb_valid_r;
        end
    end

    assign bus.req_ready = grant_s;
    assign bus.cdb_valid = cdb_valid_r;
    assign bus.cdb_tag   = cdb_tag_r;
    assign bus.cdb_out   = cdb_out_r;
    assign bus.cdb_src   = cdb_src_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter against a behavioural bus model.
module tb_cdb_arbiter;
    import tomasula_types::*;

    localparam int N  = 4;
    localparam int TW = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_UNITS(N), .TAG_W(TW)) bus ();

    cdb_arbiter #(.NUM_UNITS(N), .TAG_W(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: who holds the bus, and where round-robin resumes.
    logic          m_valid;
    logic [TW-1:0] m_tag;
    logic [31:0]   m_data;
    logic [2:0]    m_src;
    int            m_ptr;
    int            waits [N];
    logic [N-1:0]  last_ready;
    int            last_grant;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_pick();
        int idx;
        if (bus.flush || (m_valid && !bus.rob_ready)) return -1;
        for (int off = 0; off < N; off++) begin
`ifdef CDB_ROUND_ROBIN_EN
            idx = (m_ptr + off) % N;
`else
            idx = off;
`endif
            if (bus.req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_tag   = '0;
        m_data  = 32'd0;
        m_src   = 3'd0;
        m_ptr   = 0;
        for (int i = 0; i < N; i++) waits[i] = 0;
        last_ready = '0;
        last_grant = -1;
    endtask

    // Called at a negedge with inputs settled; compares, advances the model, returns at the next negedge.
    task automatic run_cycle();
        int g;
        logic [N-1:0] exp_ready;
        #1;
        g = model_pick();
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", bus.req_ready, exp_ready);
        check("cdb_valid", bus.cdb_valid, m_valid);
        if (m_valid) begin
            check("cdb_tag", bus.cdb_tag, m_tag);
            check("cdb_out", bus.cdb_out, m_data);
            check("cdb_src", bus.cdb_src, m_src);
        end
        last_ready = bus.req_ready;
        last_grant = g;
        if (g >= 0) begin
`ifdef CDB_ROUND_ROBIN_EN
            check("rr_wait_bound", (waits[g] <= N - 1), 1'b1);
`endif
            for (int i = 0; i < N; i++) begin
                if (i == g) waits[i] = 0;
                else if (bus.req_valid[i]) waits[i]++;
                else waits[i] = 0;
            end
        end
        if (bus.flush) begin
            m_valid = 1'b0;
        end else if (g >= 0) begin
            m_valid = 1'b1;
            m_tag   = bus.req_tag[g];
            m_data  = bus.req_data[g];
            m_src   = 3'(g);
            m_ptr   = (g + 1) % N;
        end else if (m_valid && bus.rob_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.req_valid = '1;
        bus.flush     = 1'b0;
        bus.rob_ready = 1'b1;
        #1;
        check("rst_cdb_valid", bus.cdb_valid, 1'b0);
        check("rst_req_ready", bus.req_ready, '0);
        @(posedge clk);
        @(negedge clk);
        check("rst_cdb_tag", bus.cdb_tag, '0);
        check("rst_cdb_out", bus.cdb_out, 32'd0);
        check("rst_cdb_src", bus.cdb_src, 3'd0);
        bus.req_valid = '0;
        rst_n         = 1'b1;
        model_reset();
    endtask

    initial begin
        int exp_seq [5];
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.rob_ready = 1'b1;
        bus.req_valid = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_tag[i]  = TW'(i);
            bus.req_data[i] = 32'h100 + 32'(i);
        end
        model_reset();
        do_reset();

        // Single request: grant now, broadcast next cycle, idle after that.
        bus.req_valid   = 4'b0001;
        bus.req_tag[0]  = 3'd5;
        bus.req_data[0] = 32'hA5;
        run_cycle();
        check("t1_grant", last_ready, 4'b0001);
        check("t1_valid", bus.cdb_valid, 1'b1);
        check("t1_tag", bus.cdb_tag, 3'd5);
        check("t1_src", bus.cdb_src, 3'd0);
        check("t1_data", bus.cdb_out, 32'hA5);
        bus.req_valid = '0;
        run_cycle();
        check("t1_idle", bus.cdb_valid, 1'b0);

        // All units requesting continuously.
        do_reset();
`ifdef CDB_ROUND_ROBIN_EN
        exp_seq = '{0, 1, 2, 3, 0};
`else
        exp_seq = '{0, 0, 0, 0, 0};
`endif
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            run_cycle();
            check("t2_grant_seq", 32'(last_grant), 32'(exp_seq[k]));
            check("t2_bus_busy", bus.cdb_valid, 1'b1);
        end

        // ROB stalls with tag 2 on the bus.
        do_reset();
        bus.req_valid  = 4'b0100;
        bus.req_tag[2] = 3'd2;
        run_cycle();
        bus.req_valid  = 4'b0010;
        bus.req_tag[1] = 3'd1;
        bus.rob_ready  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            run_cycle();
            check("t3_stall_ready", last_ready, 4'b0000);
            check("t3_stall_tag", bus.cdb_tag, 3'd2);
        end
        bus.rob_ready = 1'b1;
        run_cycle();
        check("t3_resume", last_ready, 4'b0010);

        // Flush while broadcasting; pointer must survive.
        do_reset();
        bus.req_valid = 4'b0010;
        run_cycle();
        bus.req_valid = 4'b0100;
        bus.flush     = 1'b1;
        run_cycle();
        check("t4_flush_ready", last_ready, 4'b0000);
        check("t4_flush_valid", bus.cdb_valid, 1'b0);
        bus.flush     = 1'b0;
        bus.req_valid = 4'b0101;
        run_cycle();
`ifdef CDB_ROUND_ROBIN_EN
        check("t4_ptr_kept", last_ready, 4'b0100);
`else
        check("t4_fixed_pick", last_ready, 4'b0001);
`endif
        bus.req_valid = '0;
        run_cycle();

        // Asynchronous reset in the middle of a broadcast.
        bus.req_valid = 4'b0001;
        run_cycle();
        check("t5_busy", bus.cdb_valid, 1'b1);
        bus.req_valid = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_valid", bus.cdb_valid, 1'b0);
        check("t5_async_ready", bus.req_ready, 4'b0000);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_cycle();
        check("t5_first_grant", 32'(last_grant), 32'd0);

        // Random traffic: units hold results until accepted.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (last_ready[i] || !bus.req_valid[i]) begin
                    if ($urandom_range(1, 0) == 1) begin
                        bus.req_valid[i] = 1'b1;
                        bus.req_tag[i]   = TW'($urandom);
                        bus.req_data[i]  = $urandom;
                    end else begin
                        bus.req_valid[i] = 1'b0;
                    end
                end
            end
            bus.flush     = ($urandom_range(15, 0) == 0);
            bus.rob_ready = ($urandom_range(3, 0) != 0);
            run_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
